// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions for the calculator slice.
//   - key codes presented on cmd (digits 0-9 are their own values)
//   - FSM state encoding, also exported on the debug state port
//   - status port encoding
//   - internal operator encoding plus a key-to-operator helper
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_BS  = 4'd15;

    typedef enum logic [2:0] {
        WAIT_A = 3'd0,
        WAIT_B = 3'd1,
        CALC   = 3'd2,
        SHOW   = 3'd3,
        ERROR  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        STAT_ERROR = 2'b00,
        STAT_BUSY  = 2'b01,
        STAT_READY = 2'b10,
        STAT_PRINT = 2'b11
    } status_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_t;

    // Operator keys are contiguous starting at KEY_ADD.
    function automatic op_t key_to_op(input logic [3:0] key);
        return op_t'(2'(key - KEY_ADD));
    endfunction

endpackage

// File: rtl/calc_disp_ser.sv
// calc_disp_ser: turns a binary value into a DIGITS-cycle burst of BCD
// digits, least significant digit first, leading zeros included.
//   clock, reset : system clock, asynchronous active-high reset
//   start        : one-cycle pulse; value is captured on this edge and the
//                  burst begins in the following cycle (restarts any burst)
//   value        : binary value to display (< 10^DIGITS)
//   data         : current BCD digit (0 when idle)
//   pos          : position of data, 0 = least significant (0 when idle)
//   data_valid   : high for the DIGITS cycles of the burst
//   busy         : same as data_valid; burst in progress
module calc_disp_ser
    import calc_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int W      = 27,
    parameter int PW     = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  value,
    output logic [3:0]    data,
    output logic [PW-1:0] pos,
    output logic          data_valid,
    output logic          busy
);

    localparam logic [W-1:0]  TEN  = W'(10);
    localparam logic [PW-1:0] LAST = PW'(DIGITS - 1);

    logic [W-1:0]  rest;
    logic [PW-1:0] cnt;
    logic          active;

    // rest holds the not-yet-shown digits; the displayed digit is rest % 10.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rest   <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            rest   <= value;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            rest <= rest / TEN;
            if (cnt == LAST) begin
                cnt    <= '0;
                active <= 1'b0;
            end else begin
                cnt <= cnt + PW'(1);
            end
        end
    end

    always_comb begin
        data       = active ? 4'(rest % TEN) : 4'd0;
        pos        = active ? cnt : '0;
        data_valid = active;
        busy       = active;
    end

endmodule

// File: rtl/calc_param.sv
// calc_param: key-driven decimal calculator with serial BCD display.
//   clock, reset : system clock (rising edge), asynchronous active-high reset
//   cmd          : key code (0-9 digit, 10 add, 11 sub, 12 mul, 13 div,
//                  14 '=', 15 backspace), sampled when cmd_valid=1
//   cmd_valid    : one-cycle key strobe; keys offered while ready=0 are dropped
//   ready        : key accepted this cycle
//   status       : 00 error, 01 busy (calculating), 10 ready, 11 printing
//   data, pos    : BCD digit and its position during a display burst
//   data_valid   : data/pos valid
//   state        : FSM state code (debug)
module calc_param
    import calc_pkg::*;
#(
    parameter  int DIGITS = 8,
    localparam int W      = $clog2(10 ** DIGITS),
    localparam int PW     = $clog2(DIGITS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    output logic          ready,
    output logic [1:0]    status,
    output logic [3:0]    data,
    output logic [PW-1:0] pos,
    output logic          data_valid,
    output logic [2:0]    state
);

    localparam int            CW   = $clog2(W);
    localparam logic [W:0]    MAX  = (W+1)'(10 ** DIGITS - 1);
    localparam logic [W-1:0]  FULL = W'(10 ** (DIGITS - 1));
    localparam logic [W-1:0]  TEN  = W'(10);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        cur, nxt;
    logic [W-1:0]  entry, entry_d;
    logic [W-1:0]  a, a_d;
    logic [W-1:0]  b, b_d;
    op_t           op, op_d;
    logic          typed, typed_d;      // digit entered since operator latched
    logic [CW-1:0] cnt, cnt_d;
    logic [W:0]    acc, acc_d;          // mul partial product / div remainder
    logic [W-1:0]  quo, quo_d;
    logic          ovf, ovf_d;          // sticky mul overflow

    logic          accept;
    logic          start;
    logic [W-1:0]  show_val;
    logic          busy;

    // ---------------------------------------------------------------
    // Arithmetic step logic (all W+1 bits wide, no silent wrap)
    // ---------------------------------------------------------------
    logic [CW-1:0] idx;
    logic [W:0]    dbl, mul_sum, mul_acc_nx;
    logic          mul_ovf_nx;
    logic [W:0]    div_sh, div_rem_nx;
    logic          div_ge;
    logic [W-1:0]  div_q_nx;
    logic [W:0]    add_res, sub_res;

    // Both iterative ops walk the B (mul) or A (div) bits MSB first. For mul,
    // overflow is checked after doubling and again after the add; once the
    // partial product exceeds MAX it can never come back, so the flag sticks.
    always_comb begin
        idx        = LAST - cnt;
        dbl        = acc << 1;
        mul_sum    = dbl + (b[idx] ? {1'b0, a} : '0);
        mul_ovf_nx = ovf || (dbl > MAX) || (mul_sum > MAX);
        mul_acc_nx = ovf ? acc : mul_sum;
        div_sh     = {acc[W-1:0], a[idx]};
        div_ge     = div_sh >= {1'b0, b};
        div_rem_nx = div_ge ? (div_sh - {1'b0, b}) : div_sh;
        div_q_nx   = W'({quo, div_ge});
        add_res    = {1'b0, a} + {1'b0, b};
        sub_res    = {1'b0, a} - {1'b0, b};
    end

    // ---------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cur <= WAIT_A;
        else       cur <= nxt;
    end

    // ---------------------------------------------------------------
    // Next-state and datapath next values
    // ---------------------------------------------------------------
    logic       done, bad;
    logic [W:0] res;

    always_comb begin
        nxt      = cur;
        entry_d  = entry;
        a_d      = a;
        b_d      = b;
        op_d     = op;
        typed_d  = typed;
        cnt_d    = cnt;
        acc_d    = acc;
        quo_d    = quo;
        ovf_d    = ovf;
        start    = 1'b0;
        show_val = entry;
        done     = 1'b0;
        bad      = 1'b0;
        res      = '0;

        case (cur)
            WAIT_A, WAIT_B: begin
                if (accept) begin
                    if (cmd <= 4'd9) begin
                        if (entry < FULL) begin
                            entry_d = entry * TEN + W'(cmd);
                            typed_d = 1'b1;
                        end
                    end else if (cmd == KEY_BS) begin
                        entry_d = entry / TEN;
                    end else if (cmd == KEY_EQ) begin
                        if (cur == WAIT_B) begin
                            b_d   = entry;
                            nxt   = CALC;
                            cnt_d = '0;
                            acc_d = '0;
                            quo_d = '0;
                            ovf_d = 1'b0;
                        end
                    end else if (cur == WAIT_A) begin
                        a_d     = entry;
                        op_d    = key_to_op(cmd);
                        entry_d = '0;
                        typed_d = 1'b0;
                        nxt     = WAIT_B;
                    end else if (!typed) begin
                        op_d = key_to_op(cmd);
                    end
                    // Entering CALC shows nothing; the result burst follows.
                    start    = (nxt != CALC) && ((entry_d != entry) || (nxt != cur));
                    show_val = entry_d;
                end
            end

            CALC: begin
                cnt_d = cnt + CW'(1);
                case (op)
                    OP_ADD: begin
                        bad  = add_res > MAX;
                        done = 1'b1;
                        res  = add_res;
                    end
                    OP_SUB: begin
                        bad  = b > a;
                        done = 1'b1;
                        res  = sub_res;
                    end
                    OP_MUL: begin
                        acc_d = mul_acc_nx;
                        ovf_d = mul_ovf_nx;
                        if (cnt == LAST) begin
                            bad  = mul_ovf_nx;
                            done = 1'b1;
                            res  = mul_acc_nx;
                        end
                    end
                    default: begin  // OP_DIV
                        if ((cnt == '0) && (b == '0)) begin
                            bad = 1'b1;
                        end else begin
                            acc_d = div_rem_nx;
                            quo_d = div_q_nx;
                            if (cnt == LAST) begin
                                done = 1'b1;
                                res  = {1'b0, div_q_nx};
                            end
                        end
                    end
                endcase

                if (bad) begin
                    nxt = ERROR;
                end else if (done) begin
                    entry_d  = W'(res);
                    nxt      = SHOW;
                    start    = 1'b1;
                    show_val = W'(res);
                end
            end

            SHOW: nxt = WAIT_A;

            ERROR: begin
                if (accept && (cmd == KEY_EQ)) begin
                    a_d      = '0;
                    b_d      = '0;
                    entry_d  = '0;
                    typed_d  = 1'b0;
                    nxt      = WAIT_A;
                    start    = 1'b1;
                    show_val = '0;
                end
            end

            default: nxt = WAIT_A;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            entry <= '0;
            a     <= '0;
            b     <= '0;
            op    <= OP_ADD;
            typed <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            quo   <= '0;
            ovf   <= 1'b0;
        end else begin
            entry <= entry_d;
            a     <= a_d;
            b     <= b_d;
            op    <= op_d;
            typed <= typed_d;
            cnt   <= cnt_d;
            acc   <= acc_d;
            quo   <= quo_d;
            ovf   <= ovf_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------
    always_comb begin
        ready  = (((cur == WAIT_A) || (cur == WAIT_B)) && !busy) || (cur == ERROR);
        accept = cmd_valid && ready;
        state  = cur;
        if (cur == ERROR)     status = STAT_ERROR;
        else if (cur == CALC) status = STAT_BUSY;
        else if (busy)        status = STAT_PRINT;
        else                  status = STAT_READY;
    end

    calc_disp_ser #(
        .DIGITS (DIGITS),
        .W      (W),
        .PW     (PW)
    ) u_disp (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .value      (show_val),
        .data       (data),
        .pos        (pos),
        .data_valid (data_valid),
        .busy       (busy)
    );

endmodule
